ccff_chain_loader: RTL

Configuration-chain driver for the programming side of the fabric. It accepts a bitstream as a valid/ready word stream, serialises it onto the `ccff_head` of a DFF configuration chain of `CHAIN_LEN` bits, and asserts a shift enable that gates the chain's `prog_clk`. It captures the bits emerging from `ccff_tail` as a readback word stream. It sits between the bitstream source (JTAG/SPI front end) and the first tile's `ccff_head`/last tile's `ccff_tail`, on the programming clock domain.

---
 rtl/ccff_loader_pkg.sv | 17 +
 rtl/ccff_chain_loader_if.sv | 21 ++
 rtl/ccff_readback_deser.sv | 49 ++++
 rtl/ccff_chain_loader.sv | 116 +++++++++++
 4 files changed

// File: rtl/ccff_loader_pkg.sv
// Shared types for the configuration-chain loader: FSM state encoding and
// counter sizing.
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Width of a down-counter that must hold the value n itself.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ccff_chain_loader_if.sv
// Bitstream in / readback out word streams between the loader and its
// programming front end.
interface ccff_chain_loader_if #(
  parameter int WORD_W = 8
);
  logic [WORD_W-1:0] bs_data;
  logic              bs_valid;
  logic              bs_ready;
  logic [WORD_W-1:0] rb_data;
  logic              rb_valid;

  modport master (
    output bs_data, bs_valid,
    input  bs_ready, rb_data, rb_valid
  );

  modport slave (
    input  bs_data, bs_valid,
    output bs_ready, rb_data, rb_valid
  );
endinterface

// File: rtl/ccff_readback_deser.sv
// Collects bits leaving the chain tail into words, bit 0 = first captured,
// and strobes each full (or final partial) word for one cycle.
module ccff_readback_deser
  import ccff_loader_pkg::*;
#(
  parameter int WORD_W = 8
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              shift_en,
  input  logic              tail,
  input  logic              last_bit,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid
);

  localparam int CW = cnt_w(WORD_W);

  logic [CW-1:0]     rb_cnt;
  logic [WORD_W-1:0] rb_sreg;
  logic [WORD_W-1:0] rb_next;

  // rb_sreg stays zero above rb_cnt, so OR-ing in the new bit is enough and a
  // partial final word naturally has its unused upper bits at 0.
  assign rb_next = rb_sreg | (WORD_W'(tail) << rb_cnt);

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      rb_cnt   <= '0;
      rb_sreg  <= '0;
      rb_data  <= '0;
      rb_valid <= 1'b0;
    end else begin
      rb_valid <= 1'b0;
      if (shift_en) begin
        if (rb_cnt == CW'(WORD_W - 1) || last_bit) begin
          rb_data  <= rb_next;
          rb_valid <= 1'b1;
          rb_cnt   <= '0;
          rb_sreg  <= '0;
        end else begin
          rb_sreg <= rb_next;
          rb_cnt  <= rb_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/ccff_chain_loader.sv
// Serialises a bitstream word stream onto a DFF configuration chain and
// returns the displaced chain contents as a readback word stream.
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 65,
  parameter int WORD_W    = 8
) (
  input  logic                prog_clk,
  input  logic                pReset,
  input  logic                start,
  ccff_chain_loader_if.slave  bs,
  output logic                ccff_head,
  output logic                ccff_shift_en,
  input  logic                ccff_tail,
  output logic                busy,
  output logic                done
);

  localparam int TW = cnt_w(CHAIN_LEN);
  localparam int WW = cnt_w(WORD_W);

  state_t            state;
  logic [TW-1:0]     total_left;
  logic [WW-1:0]     word_left;
  logic [WORD_W-1:0] sreg;
  logic              shift_en_q;
  logic              last_word_bit;
  logic              last_bit;

  // Bits of a freshly loaded word that still belong to the chain.
  function automatic logic [WW-1:0] fill(input logic [TW-1:0] t);
    if (int'(t) < WORD_W) return WW'(t);
    return WW'(WORD_W);
  endfunction

  assign last_word_bit = (state == SHIFT) && (word_left == WW'(1));
  assign last_bit      = shift_en_q && (total_left == TW'(1));

  // Accept in FETCH, or on the final bit of a word so the next word follows
  // with no idle shift cycle.
  assign bs.bs_ready = (state == FETCH) ||
                       (last_word_bit && (total_left != TW'(1)) && bs.bs_valid);

  assign ccff_head     = sreg[0];
  assign ccff_shift_en = shift_en_q;

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state      <= IDLE;
      total_left <= '0;
      word_left  <= '0;
      sreg       <= '0;
      shift_en_q <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            total_left <= TW'(CHAIN_LEN);
            busy       <= 1'b1;
            state      <= FETCH;
          end
        end
        FETCH: begin
          if (bs.bs_valid) begin
            sreg       <= bs.bs_data;
            word_left  <= fill(total_left);
            shift_en_q <= 1'b1;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          sreg       <= sreg >> 1;
          word_left  <= word_left - WW'(1);
          total_left <= total_left - TW'(1);
          if (word_left == WW'(1)) begin
            if (total_left == TW'(1)) begin
              // Clear leftovers of a partial final word so head idles low.
              sreg       <= '0;
              shift_en_q <= 1'b0;
              done       <= 1'b1;
              state      <= DONE;
            end else if (bs.bs_valid) begin
              sreg      <= bs.bs_data;
              word_left <= fill(total_left - TW'(1));
            end else begin
              shift_en_q <= 1'b0;
              state      <= FETCH;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  ccff_readback_deser #(
    .WORD_W (WORD_W)
  ) u_rb (
    .prog_clk (prog_clk),
    .pReset   (pReset),
    .shift_en (shift_en_q),
    .tail     (ccff_tail),
    .last_bit (last_bit),
    .rb_data  (bs.rb_data),
    .rb_valid (bs.rb_valid)
  );

endmodule
